// File: rtl/svo_stream_sink.sv
// svo_stream_sink
//
// Consumer end of the SVO AXI-stream video pipeline. Locks to frame
// boundaries using the start-of-frame flag in tuser, tracks the pixel
// position, checks framing, and accumulates per-channel colour sums over
// each complete frame. It also generates periodic back-pressure so that
// sources are exercised under tready stalls.
//
// Ports:
//   clk              single clock
//   resetn           asynchronous active-low reset
//   in_axis_tvalid   source has a pixel
//   in_axis_tready   sink accepts (registered)
//   in_axis_tdata    pixel as {b, g, r}, r in the LSBs
//   in_axis_tuser    start of frame
//   frame_done       one-cycle pulse after the last beat of a full frame
//   frame_r/g/b_sum  channel sums of the last complete frame
//   frame_count      complete frames received, wraps at 16 bits
//   err_early_sof    one-cycle pulse: SOF seen away from (0,0)
//   err_missing_sof  one-cycle pulse: SOF absent at (0,0)
//   locked           high while in the ACTIVE state
module svo_stream_sink #(
  parameter int SVO_HOR_PIXELS     = 640,
  parameter int SVO_VER_PIXELS     = 480,
  parameter int SVO_BITS_PER_RED   = 8,
  parameter int SVO_BITS_PER_GREEN = 8,
  parameter int SVO_BITS_PER_BLUE  = 8,
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int STALL_PERIOD       = 0,
  parameter int SUM_BITS           = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic                          in_axis_tuser,
  output logic                          frame_done,
  output logic [SUM_BITS-1:0]           frame_r_sum,
  output logic [SUM_BITS-1:0]           frame_g_sum,
  output logic [SUM_BITS-1:0]           frame_b_sum,
  output logic [15:0]                   frame_count,
  output logic                          err_early_sof,
  output logic                          err_missing_sof,
  output logic                          locked
);

  localparam int HW = (SVO_HOR_PIXELS > 1) ? $clog2(SVO_HOR_PIXELS) : 1;
  localparam int VW = (SVO_VER_PIXELS > 1) ? $clog2(SVO_VER_PIXELS) : 1;
  localparam int RB = SVO_BITS_PER_RED;
  localparam int GB = SVO_BITS_PER_GREEN;
  localparam int BB = SVO_BITS_PER_BLUE;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0]       hcursor, hcursor_nxt, hcursor_base;
  logic [VW-1:0]       vcursor, vcursor_nxt, vcursor_base;
  logic [SUM_BITS-1:0] acc_r, acc_g, acc_b;
  logic [SUM_BITS-1:0] pix_r, pix_g, pix_b;

  logic accept, at_origin, at_last;
  logic do_load, do_add, do_early, do_missing;

  // Accumulation wraps modulo 2^SUM_BITS by construction.
  function automatic logic [SUM_BITS-1:0] acc_wrap_add(
    input logic [SUM_BITS-1:0] a,
    input logic [SUM_BITS-1:0] b
  );
    return a + b;
  endfunction

  assign pix_r = SUM_BITS'(in_axis_tdata[RB-1:0]);
  assign pix_g = SUM_BITS'(in_axis_tdata[RB+GB-1:RB]);
  assign pix_b = SUM_BITS'(in_axis_tdata[RB+GB+BB-1:RB+GB]);

  assign accept    = in_axis_tvalid && in_axis_tready;
  assign at_origin = (hcursor == '0) && (vcursor == '0);
  assign at_last   = (hcursor == HW'(SVO_HOR_PIXELS - 1)) &&
                     (vcursor == VW'(SVO_VER_PIXELS - 1));
  assign locked    = (state == ACTIVE);

  // ---------------------------------------------------------------------
  // Back-pressure: tready is registered from the next stall count, so it
  // is low exactly while the counter sits at STALL_PERIOD-1.
  // ---------------------------------------------------------------------
  generate
    if (STALL_PERIOD >= 2) begin : g_stall
      localparam int SW = $clog2(STALL_PERIOD);
      logic [SW-1:0] stall_cnt, stall_nxt;

      always_comb begin
        stall_nxt = stall_cnt + SW'(1);
        if (stall_cnt == SW'(STALL_PERIOD - 1)) stall_nxt = '0;
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          stall_cnt      <= '0;
          in_axis_tready <= 1'b0;
        end else begin
          stall_cnt      <= stall_nxt;
          in_axis_tready <= (stall_nxt != SW'(STALL_PERIOD - 1));
        end
      end
    end else begin : g_no_stall
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) in_axis_tready <= 1'b0;
        else         in_axis_tready <= 1'b1;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Frame-lock FSM: classifies each accepted beat.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= SYNC;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_add     = 1'b0;
    do_early   = 1'b0;
    do_missing = 1'b0;
    if (accept) begin
      unique case (state)
        SYNC: begin
          if (in_axis_tuser) begin
            state_nxt = ACTIVE;
            do_load   = 1'b1;
          end
        end
        ACTIVE: begin
          if (in_axis_tuser && !at_origin) begin
            do_early = 1'b1;
            do_load  = 1'b1;
          end else if (!in_axis_tuser && at_origin) begin
            do_missing = 1'b1;
            state_nxt  = SYNC;
          end else if (at_origin) begin
            do_load = 1'b1;
          end else begin
            do_add = 1'b1;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  // Position advance; a loaded beat always counts as pixel (0,0).
  always_comb begin
    hcursor_base = do_load ? '0 : hcursor;
    vcursor_base = do_load ? '0 : vcursor;
    hcursor_nxt  = hcursor_base + HW'(1);
    vcursor_nxt  = vcursor_base;
    if (hcursor_base == HW'(SVO_HOR_PIXELS - 1)) begin
      hcursor_nxt = '0;
      vcursor_nxt = vcursor_base + VW'(1);
      if (vcursor_base == VW'(SVO_VER_PIXELS - 1)) vcursor_nxt = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Position, accumulators and frame results.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcursor         <= '0;
      vcursor         <= '0;
      acc_r           <= '0;
      acc_g           <= '0;
      acc_b           <= '0;
      frame_r_sum     <= '0;
      frame_g_sum     <= '0;
      frame_b_sum     <= '0;
      frame_count     <= '0;
      frame_done      <= 1'b0;
      err_early_sof   <= 1'b0;
      err_missing_sof <= 1'b0;
    end else begin
      frame_done      <= do_add && at_last;
      err_early_sof   <= do_early;
      err_missing_sof <= do_missing;
      if (do_load) begin
        acc_r   <= pix_r;
        acc_g   <= pix_g;
        acc_b   <= pix_b;
        hcursor <= hcursor_nxt;
        vcursor <= vcursor_nxt;
      end else if (do_add) begin
        hcursor <= hcursor_nxt;
        vcursor <= vcursor_nxt;
        if (at_last) begin
          frame_r_sum <= acc_wrap_add(acc_r, pix_r);
          frame_g_sum <= acc_wrap_add(acc_g, pix_g);
          frame_b_sum <= acc_wrap_add(acc_b, pix_b);
          frame_count <= frame_count + 16'd1;
          acc_r       <= '0;
          acc_g       <= '0;
          acc_b       <= '0;
        end else begin
          acc_r <= acc_wrap_add(acc_r, pix_r);
          acc_g <= acc_wrap_add(acc_g, pix_g);
          acc_b <= acc_wrap_add(acc_b, pix_b);
        end
      end else if (do_missing) begin
        acc_r   <= '0;
        acc_g   <= '0;
        acc_b   <= '0;
        hcursor <= '0;
        vcursor <= '0;
      end
    end
  end

endmodule

// File: tb/tb_svo_stream_sink.sv
`timescale 1ns/1ps
module tb_svo_stream_sink;

  localparam int HOR  = 4;
  localparam int VER  = 3;
  localparam int NPIX = HOR * VER;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // sel picks which instance the stimulus and observations apply to:
  // 0 = no back-pressure, 1 = STALL_PERIOD 3.
  logic        sel = 1'b0;
  logic        tv = 1'b0;
  logic        sof = 1'b0;
  logic [23:0] tdata = '0;

  logic        tvalid0, tvalid1, tready0, tready1;
  logic        done0, done1, early0, early1, miss0, miss1, locked0, locked1;
  logic [31:0] rs0, gs0, bs0, rs1, gs1, bs1;
  logic [15:0] cnt0, cnt1;

  assign tvalid0 = tv & ~sel;
  assign tvalid1 = tv & sel;

  svo_stream_sink #(
    .SVO_HOR_PIXELS(HOR), .SVO_VER_PIXELS(VER), .STALL_PERIOD(0), .SUM_BITS(32)
  ) dut0 (
    .clk(clk), .resetn(resetn),
    .in_axis_tvalid(tvalid0), .in_axis_tready(tready0),
    .in_axis_tdata(tdata), .in_axis_tuser(sof),
    .frame_done(done0), .frame_r_sum(rs0), .frame_g_sum(gs0), .frame_b_sum(bs0),
    .frame_count(cnt0), .err_early_sof(early0), .err_missing_sof(miss0),
    .locked(locked0)
  );

  svo_stream_sink #(
    .SVO_HOR_PIXELS(HOR), .SVO_VER_PIXELS(VER), .STALL_PERIOD(3), .SUM_BITS(32)
  ) dut1 (
    .clk(clk), .resetn(resetn),
    .in_axis_tvalid(tvalid1), .in_axis_tready(tready1),
    .in_axis_tdata(tdata), .in_axis_tuser(sof),
    .frame_done(done1), .frame_r_sum(rs1), .frame_g_sum(gs1), .frame_b_sum(bs1),
    .frame_count(cnt1), .err_early_sof(early1), .err_missing_sof(miss1),
    .locked(locked1)
  );

  logic        o_ready, o_done, o_early, o_miss, o_locked;
  logic [31:0] o_rs, o_gs, o_bs;
  logic [15:0] o_cnt;
  assign o_ready  = sel ? tready1 : tready0;
  assign o_done   = sel ? done1   : done0;
  assign o_early  = sel ? early1  : early0;
  assign o_miss   = sel ? miss1   : miss0;
  assign o_locked = sel ? locked1 : locked0;
  assign o_rs     = sel ? rs1     : rs0;
  assign o_gs     = sel ? gs1     : gs0;
  assign o_bs     = sel ? bs1     : bs0;
  assign o_cnt    = sel ? cnt1    : cnt0;

  // Clock edges since the last reset release.
  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frames are gathered as a list of pixels; a frame is
  // complete when the list holds HOR*VER pixels that began with an SOF.
  logic [23:0] fq[$];
  bit          in_frame;
  bit          exp_done, exp_early, exp_miss;
  logic [31:0] exp_r, exp_g, exp_b;
  logic [15:0] exp_cnt;

  task automatic model_clear();
    fq.delete();
    in_frame  = 0;
    exp_done  = 0;
    exp_early = 0;
    exp_miss  = 0;
    exp_r     = '0;
    exp_g     = '0;
    exp_b     = '0;
    exp_cnt   = '0;
  endtask

  // One clock of stimulus; outputs are left at 1 ns after the edge.
  task automatic send(input bit v, input bit s, input logic [23:0] d, output bit acc);
    bit rdy;
    @(negedge clk);
    tv    = v;
    sof   = s;
    tdata = d;
    rdy   = o_ready;
    @(posedge clk);
    acc       = v && rdy;
    exp_done  = 0;
    exp_early = 0;
    exp_miss  = 0;
    if (acc) begin
      if (s) begin
        if (in_frame && fq.size() != 0) exp_early = 1;
        fq.delete();
        fq.push_back(d);
        in_frame = 1;
      end else if (in_frame) begin
        if (fq.size() == 0) begin
          exp_miss = 1;
          in_frame = 0;
        end else begin
          fq.push_back(d);
        end
      end
      if (in_frame && fq.size() == NPIX) begin
        exp_r = '0; exp_g = '0; exp_b = '0;
        foreach (fq[i]) begin
          exp_r += 32'(fq[i][7:0]);
          exp_g += 32'(fq[i][15:8]);
          exp_b += 32'(fq[i][23:16]);
        end
        exp_done = 1;
        exp_cnt  = exp_cnt + 16'd1;
        fq.delete();
      end
    end
    #1;
    tv = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    tv = 0;
    resetn = 0;
    model_clear();
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    sel = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tready0 !== 1'b0) $display("FAIL rst_tready0 got %b want 0", tready0); else n_pass++;
    n_checks++; if (tready1 !== 1'b0) $display("FAIL rst_tready1 got %b want 0", tready1); else n_pass++;
    n_checks++; if ({done0, early0, miss0, locked0} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {done0, early0, miss0, locked0}); else n_pass++;
    n_checks++; if ({rs0, gs0, bs0, cnt0} !== '0) $display("FAIL rst_sums got %0d/%0d/%0d cnt %0d want 0", rs0, gs0, bs0, cnt0); else n_pass++;
    @(negedge clk);
    resetn = 1;
    n_checks++; if (tready0 !== 1'b0) $display("FAIL rst_tready_before_edge got %b want 0", tready0); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (tready0 !== 1'b1) $display("FAIL rst_tready0_rise got %b want 1", tready0); else n_pass++;
    n_checks++; if (tready1 !== 1'b1) $display("FAIL rst_tready1_rise got %b want 1", tready1); else n_pass++;
  endtask

  task automatic test_constant();
    bit a;
    int nd, first_i, last_i;
    apply_reset();
    sel = 0; nd = 0; first_i = -1; last_i = -1;
    for (int i = 0; i < 2 * NPIX; i++) begin
      send(1, (i % NPIX) == 0, 24'h030201, a);
      n_checks++; if (o_done !== exp_done) $display("FAIL const_done beat %0d got %b want %b", i, o_done, exp_done); else n_pass++;
      n_checks++; if ({o_early, o_miss} !== 2'b00) $display("FAIL const_err beat %0d got %b want 00", i, {o_early, o_miss}); else n_pass++;
      if (o_done) begin
        if (nd == 0) first_i = i;
        last_i = i;
        nd++;
      end
    end
    n_checks++; if (nd !== 2) $display("FAIL const_ndone got %0d want 2", nd); else n_pass++;
    n_checks++; if (last_i - first_i !== 12) $display("FAIL const_spacing got %0d want 12", last_i - first_i); else n_pass++;
    n_checks++; if ({o_rs, o_gs, o_bs} !== {32'd12, 32'd24, 32'd36}) $display("FAIL const_sums got %0d/%0d/%0d want 12/24/36", o_rs, o_gs, o_bs); else n_pass++;
    n_checks++; if (o_cnt !== 16'd2) $display("FAIL const_count got %0d want 2", o_cnt); else n_pass++;
  endtask

  task automatic test_lockup();
    bit a;
    int nd;
    apply_reset();
    sel = 0; nd = 0;
    for (int i = 0; i < 5; i++) begin
      send(1, 0, 24'($urandom), a);
      n_checks++; if ({o_early, o_miss, o_locked} !== 3'b000) $display("FAIL lock_pre beat %0d got %b want 000", i, {o_early, o_miss, o_locked}); else n_pass++;
    end
    for (int i = 0; i < NPIX; i++) begin
      send(1, i == 0, 24'($urandom), a);
      n_checks++; if (o_done !== exp_done) $display("FAIL lock_done beat %0d got %b want %b", i, o_done, exp_done); else n_pass++;
      n_checks++; if (o_locked !== in_frame) $display("FAIL lock_locked beat %0d got %b want %b", i, o_locked, in_frame); else n_pass++;
      if (o_done) nd++;
    end
    n_checks++; if (nd !== 1) $display("FAIL lock_ndone got %0d want 1", nd); else n_pass++;
    n_checks++; if ({o_rs, o_gs, o_bs} !== {exp_r, exp_g, exp_b}) $display("FAIL lock_sums got %0d/%0d/%0d want %0d/%0d/%0d", o_rs, o_gs, o_bs, exp_r, exp_g, exp_b); else n_pass++;
    n_checks++; if (o_cnt !== 16'd1) $display("FAIL lock_count got %0d want 1", o_cnt); else n_pass++;
  endtask

  task automatic test_early_sof();
    bit a;
    int nd, ne, early_at;
    logic [23:0] d;
    logic [31:0] local_r;
    apply_reset();
    sel = 0; nd = 0; ne = 0; early_at = -1; local_r = '0;
    for (int i = 0; i < 7 + NPIX; i++) begin
      d = 24'($urandom);
      if (i >= 7) local_r += 32'(d[7:0]);
      send(1, (i == 0) || (i == 7), d, a);
      n_checks++; if ({o_done, o_early, o_miss} !== {exp_done, exp_early, exp_miss}) $display("FAIL early_flags beat %0d got %b want %b", i, {o_done, o_early, o_miss}, {exp_done, exp_early, exp_miss}); else n_pass++;
      if (o_early) begin ne++; early_at = i; end
      if (o_done) nd++;
    end
    n_checks++; if ((ne !== 1) || (early_at !== 7)) $display("FAIL early_pulse got %0d pulses at %0d want 1 at 7", ne, early_at); else n_pass++;
    n_checks++; if (nd !== 1) $display("FAIL early_ndone got %0d want 1", nd); else n_pass++;
    n_checks++; if (o_rs !== local_r) $display("FAIL early_rsum got %0d want %0d", o_rs, local_r); else n_pass++;
    n_checks++; if ({o_gs, o_bs} !== {exp_g, exp_b}) $display("FAIL early_gbsum got %0d/%0d want %0d/%0d", o_gs, o_bs, exp_g, exp_b); else n_pass++;
  endtask

  task automatic test_missing_sof();
    bit a;
    apply_reset();
    sel = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        send(1, (i == 0) && (f != 1), 24'($urandom), a);
        n_checks++; if ({o_done, o_early, o_miss} !== {exp_done, exp_early, exp_miss}) $display("FAIL miss_flags frame %0d beat %0d got %b want %b", f, i, {o_done, o_early, o_miss}, {exp_done, exp_early, exp_miss}); else n_pass++;
        n_checks++; if (o_locked !== in_frame) $display("FAIL miss_locked frame %0d beat %0d got %b want %b", f, i, o_locked, in_frame); else n_pass++;
        if ((f == 1) && (i == 0)) begin
          n_checks++; if ({o_miss, o_locked} !== 2'b10) $display("FAIL miss_pulse got miss=%b locked=%b want 1/0", o_miss, o_locked); else n_pass++;
        end
      end
      if (f == 1) begin
        n_checks++; if (o_cnt !== 16'd1) $display("FAIL miss_count_held got %0d want 1", o_cnt); else n_pass++;
      end
    end
    n_checks++; if ({o_cnt, o_locked} !== {16'd2, 1'b1}) $display("FAIL miss_recover got cnt %0d locked %b want 2/1", o_cnt, o_locked); else n_pass++;
    n_checks++; if ({o_rs, o_gs, o_bs} !== {exp_r, exp_g, exp_b}) $display("FAIL miss_sums got %0d/%0d/%0d want %0d/%0d/%0d", o_rs, o_gs, o_bs, exp_r, exp_g, exp_b); else n_pass++;
  endtask

  task automatic test_back_pressure();
    bit a, want_rdy;
    int idx, nd;
    logic [15:0] gb[NPIX];
    apply_reset();
    sel = 1; idx = 0; nd = 0;
    for (int i = 0; i < NPIX; i++) gb[i] = 16'($urandom);
    for (int c = 0; (c < 60) && (idx < NPIX); c++) begin
      send(1, idx == 0, {gb[idx], 8'(idx)}, a);
      want_rdy = ((cyc - 1) % 3) != 2;
      n_checks++; if (a !== want_rdy) $display("FAIL bp_tready cycle %0d got %b want %b", cyc - 1, a, want_rdy); else n_pass++;
      n_checks++; if (o_done !== exp_done) $display("FAIL bp_done cycle %0d got %b want %b", c, o_done, exp_done); else n_pass++;
      n_checks++; if (tready0 !== 1'b1) $display("FAIL bp_nostall_tready got %b want 1", tready0); else n_pass++;
      if (o_done) nd++;
      if (a) idx++;
    end
    n_checks++; if (idx !== NPIX) $display("FAIL bp_beats got %0d want %0d", idx, NPIX); else n_pass++;
    n_checks++; if (nd !== 1) $display("FAIL bp_ndone got %0d want 1", nd); else n_pass++;
    n_checks++; if (o_rs !== 32'd66) $display("FAIL bp_rsum got %0d want 66", o_rs); else n_pass++;
    n_checks++; if ({o_gs, o_bs, o_cnt} !== {exp_g, exp_b, 16'd1}) $display("FAIL bp_gb got %0d/%0d cnt %0d want %0d/%0d/1", o_gs, o_bs, o_cnt, exp_g, exp_b); else n_pass++;
    sel = 0;
  endtask

  task automatic test_reset_mid_frame();
    bit a;
    apply_reset();
    sel = 0;
    for (int i = 0; i < NPIX + 5; i++) send(1, (i % NPIX) == 0, 24'($urandom), a);
    n_checks++; if (o_cnt !== 16'd1) $display("FAIL rmid_pre_count got %0d want 1", o_cnt); else n_pass++;
    @(negedge clk);
    #2;
    resetn = 0;
    model_clear();
    #1;
    n_checks++; if ({tready0, done0, early0, miss0, locked0} !== 5'b0) $display("FAIL rmid_flags got %b want 00000", {tready0, done0, early0, miss0, locked0}); else n_pass++;
    n_checks++; if ({rs0, gs0, bs0, cnt0} !== '0) $display("FAIL rmid_sums got %0d/%0d/%0d cnt %0d want 0", rs0, gs0, bs0, cnt0); else n_pass++;
    @(negedge clk);
    resetn = 1;
    for (int i = 0; i < NPIX; i++) begin
      send(1, i == 0, 24'($urandom), a);
      n_checks++; if (o_done !== exp_done) $display("FAIL rmid_done beat %0d got %b want %b", i, o_done, exp_done); else n_pass++;
    end
    n_checks++; if (o_cnt !== 16'd1) $display("FAIL rmid_count got %0d want 1", o_cnt); else n_pass++;
    n_checks++; if ({o_rs, o_gs, o_bs} !== {exp_r, exp_g, exp_b}) $display("FAIL rmid_sums_after got %0d/%0d/%0d want %0d/%0d/%0d", o_rs, o_gs, o_bs, exp_r, exp_g, exp_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_lockup();
    test_early_sof();
    test_missing_sof();
    test_back_pressure();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
